// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and widths for the ALU command sequencer
package alu_seq_pkg;

  localparam int OPC_W     = 4;
  localparam int DATA_W    = 8;
  // Widest tag the queue can carry; the top keeps only its TAG_W low bits.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [TAG_MAX_W-1:0] tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, DEPTH entries of alu_cmd_t
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  alu_cmd_t                 push_data,
  input  logic                     pop,
  output alu_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - single-issue command sequencer for the 8-bit ALU; ALU_SEQ_STATS_EN adds result counters
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 4,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_enable,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_of,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_of,
  output logic [TAG_W-1:0]  res_tag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_done,
  output logic [15:0]       stat_of
`endif
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  seq_state_t              state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    alu_enable_d;
  logic [OPC_W-1:0]        alu_opcode_d;
  logic [DATA_W-1:0]       alu_a_d, alu_b_d;
  logic                    res_valid_d;
  logic [DATA_W-1:0]       res_data_d;
  logic                    res_cout_d, res_of_d;
  logic [TAG_W-1:0]        res_tag_d;

  alu_cmd_t                cmd_in;
  alu_cmd_t                head;
  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    res_fire;
  logic                    unused_fifo;

  assign cmd_in.opcode = cmd_opcode;
  assign cmd_in.a      = cmd_a;
  assign cmd_in.b      = cmd_b;
  assign cmd_in.tag    = TAG_MAX_W'(cmd_tag);

  assign cmd_ready   = !fifo_full;
  assign res_fire    = res_valid && res_ready;
  assign unused_fifo = ^{fifo_count, head.tag >> TAG_W};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    tag_d        = tag_q;
    fifo_pop     = 1'b0;
    alu_enable_d = alu_enable;
    alu_opcode_d = alu_opcode;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    res_valid_d  = res_valid;
    res_data_d   = res_data;
    res_cout_d   = res_cout;
    res_of_d     = res_of;
    res_tag_d    = res_tag;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          alu_enable_d = 1'b1;
          alu_opcode_d = head.opcode;
          alu_a_d      = head.a;
          alu_b_d      = head.b;
          tag_d        = head.tag[TAG_W-1:0];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = CNT_W'(1);
        state_d    = WAIT;
      end
      WAIT: begin
        // Capture on the edge where the counter already reads ALU_LAT.
        if (wait_cnt_q == CNT_W'(ALU_LAT)) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_out;
          res_cout_d  = alu_cout;
          res_of_d    = alu_of;
          res_tag_d   = tag_q;
          state_d     = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (res_fire) begin
          res_valid_d  = 1'b0;
          alu_enable_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tag_q      <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      res_of     <= 1'b0;
      res_tag    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
      alu_enable <= alu_enable_d;
      alu_opcode <= alu_opcode_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      res_valid  <= res_valid_d;
      res_data   <= res_data_d;
      res_cout   <= res_cout_d;
      res_of     <= res_of_d;
      res_tag    <= res_tag_d;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_done <= '0;
      stat_of   <= '0;
    end else if (res_fire) begin
      if (stat_done != 16'hFFFF)          stat_done <= stat_done + 16'd1;
      if (res_of && stat_of != 16'hFFFF)  stat_of   <= stat_of + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a pipelined ALU model
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 4;
  localparam int TAG_W   = 4;
  localparam int N_VEC   = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode = '0;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             alu_enable;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_a, alu_b;
  logic [7:0]       alu_out;
  logic             alu_cout, alu_of;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [7:0]       res_data;
  logic             res_cout, res_of;
  logic [TAG_W-1:0] res_tag;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]      stat_done, stat_of;
`endif

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_of(res_of), .res_tag(res_tag)
`ifdef ALU_SEQ_STATS_EN
    , .stat_done(stat_done), .stat_of(stat_of)
`endif
  );

  always #5 clk = ~clk;

  // ALU model: returns {cout, of, out}; op2 flags unsigned overflow, op3/op5 signed.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      4'd0: return {2'b00, a & b};
      4'd1: return {2'b00, a | b};
      4'd2: begin s = {1'b0, a} + {1'b0, b}; return {s[8], s[8], s[7:0]}; end
      4'd3: begin s = {1'b0, a} + {1'b0, b}; return {s[8], (a[7] == b[7]) && (s[7] != a[7]), s[7:0]}; end
      4'd4: return {2'b00, a ^ b};
      4'd5: begin s = {1'b0, a} - {1'b0, b}; return {s[8], (a[7] != b[7]) && (s[7] != a[7]), s[7:0]}; end
      default: return 10'h000;
    endcase
  endfunction

  // ALU_LAT-stage pipeline; unfinished slots present a poison value.
  logic [10:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {alu_enable, alu_fn(alu_opcode, alu_a, alu_b)};
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {alu_cout, alu_of, alu_out} = pipe[ALU_LAT-1][10] ? pipe[ALU_LAT-1][9:0] : 10'h2A5;

  int cyc = 0;
  int hs_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && res_valid && res_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic [3:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [7:0]       data;
    logic             cout;
    logic             of;
  } vec_t;

  vec_t vecs [N_VEC];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 64) begin
      tick();
      n++;
    end
    check(name, 40'(res_valid), 40'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic        early, moved, rose, acc;
  logic [34:0] snap;
  int          n_acc, n_of_exp;
  int          t_res [4];

  initial begin
    vecs[0] = '{4'd2, 8'h05, 8'h03, 4'd1,  8'h08, 1'b0, 1'b0};
    vecs[1] = '{4'd2, 8'hFF, 8'h01, 4'd2,  8'h00, 1'b1, 1'b1};
    vecs[2] = '{4'd3, 8'h7F, 8'h01, 4'd3,  8'h80, 1'b0, 1'b1};
    vecs[3] = '{4'd3, 8'hFF, 8'hFF, 4'd4,  8'hFE, 1'b1, 1'b0};
    vecs[4] = '{4'd0, 8'hF0, 8'h3C, 4'd5,  8'h30, 1'b0, 1'b0};
    vecs[5] = '{4'd1, 8'hF0, 8'h0F, 4'd6,  8'hFF, 1'b0, 1'b0};
    vecs[6] = '{4'd4, 8'hAA, 8'hFF, 4'd7,  8'h55, 1'b0, 1'b0};
    vecs[7] = '{4'd5, 8'h10, 8'h20, 4'd8,  8'hF0, 1'b1, 1'b0};
    vecs[8] = '{4'd2, 8'h80, 8'h80, 4'd15, 8'h00, 1'b1, 1'b1};

    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_cmd_ready", 40'(cmd_ready), 40'd1);
    check("rst_alu", 40'({alu_enable, alu_opcode, alu_a, alu_b}), 40'd0);
    check("rst_res", 40'({res_valid, res_data, res_cout, res_of, res_tag}), 40'd0);

    // Single commands from idle: latency, operand issue, capture and release.
    n_of_exp = 0;
    for (int i = 0; i < N_VEC; i++) begin
      if (vecs[i].of) n_of_exp++;
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      tick();
      check("issue_enable", 40'(alu_enable), 40'd1);
      check("issue_operands", 40'({alu_opcode, alu_a, alu_b}), 40'({vecs[i].op, vecs[i].a, vecs[i].b}));
      early = 1'b0;
      for (int k = 2; k < ALU_LAT + 2; k++) begin
        tick();
        if (res_valid) early = 1'b1;
      end
      check("early_valid", 40'(early), 40'd0);
      tick();
      check("res_valid", 40'(res_valid), 40'd1);
      check("res_data", 40'(res_data), 40'(vecs[i].data));
      check("res_flags", 40'({res_cout, res_of}), 40'({vecs[i].cout, vecs[i].of}));
      check("res_tag", 40'(res_tag), 40'(vecs[i].tag));
      tick();
      check("release", 40'({res_valid, alu_enable}), 40'd0);
    end
`ifdef ALU_SEQ_STATS_EN
    check("stat_done", 40'(stat_done), 40'(N_VEC));
    check("stat_of", 40'(stat_of), 40'(n_of_exp));
`endif

    // Fill with the result stalled: one in flight plus DEPTH queued.
    res_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 4'd2;
      cmd_a      = 8'(n_acc * 16 + 1);
      cmd_b      = 8'h01;
      cmd_tag    = TAG_W'(n_acc);
      acc = cmd_ready;
      tick();
      if (acc) n_acc++;
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 40'(n_acc), 40'd5);
    check("fill_ready_low", 40'(cmd_ready), 40'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_res("drain_valid");
      check("drain_tag", 40'(res_tag), 40'(k));
      check("drain_data", 40'(res_data), 40'(k * 16 + 2));
      tick();
    end
    check("drain_ready", 40'(cmd_ready), 40'd1);

    // Back-to-back throughput with res_ready held high.
    for (int k = 0; k < 4; k++) send(4'd1, 8'(k), 8'h10, TAG_W'(k));
    for (int k = 0; k < 4; k++) begin
      wait_res("b2b_valid");
      t_res[k] = cyc;
      check("b2b_tag", 40'(res_tag), 40'(k));
      check("b2b_data", 40'(res_data), 40'(8'h10 + k));
      if (k > 0) check("b2b_spacing", 40'(t_res[k] - t_res[k-1]), 40'(ALU_LAT + 3));
      tick();
    end

    // Downstream stall in DONE: everything holds, exactly one handshake on release.
    res_ready = 1'b0;
    send(4'd3, 8'h7F, 8'h01, 4'd9);
    wait_res("stall_valid");
    snap  = {res_data, res_cout, res_of, res_tag, alu_opcode, alu_a, alu_b, alu_enable};
    moved = 1'b0;
    repeat (10) begin
      tick();
      if ({res_data, res_cout, res_of, res_tag, alu_opcode, alu_a, alu_b, alu_enable} !== snap || !res_valid)
        moved = 1'b1;
    end
    check("stall_hold", 40'(moved), 40'd0);
    check("stall_result", 40'({res_data, res_cout, res_of, res_tag}), 40'({8'h80, 1'b0, 1'b1, 4'd9}));
    hs_cnt = 0;
    res_ready = 1'b1;
    tick();
    check("stall_release", 40'(res_valid), 40'd0);
    repeat (8) tick();
    check("stall_handshakes", 40'(hs_cnt), 40'd1);

    // Reset mid-WAIT with two commands still queued.
    send(4'd4, 8'h0A, 8'h0F, 4'd10);
    send(4'd4, 8'h0B, 8'h0F, 4'd11);
    send(4'd4, 8'h0C, 8'h0F, 4'd12);
    tick();
    #2 reset = 1'b0;
    #1;
    check("midwait_ctrl", 40'({cmd_ready, alu_enable, res_valid}), 40'({1'b1, 1'b0, 1'b0}));
    check("midwait_alu", 40'({alu_opcode, alu_a, alu_b}), 40'd0);
    check("midwait_res", 40'({res_data, res_cout, res_of, res_tag}), 40'd0);
    tick();
    tick();
    reset = 1'b1;
    rose  = 1'b0;
    repeat (20) begin
      tick();
      if (res_valid || alu_enable) rose = 1'b1;
    end
    check("midwait_dropped", 40'(rose), 40'd0);

    send(4'd2, 8'h21, 8'h12, 4'd6);
    wait_res("post_reset_valid");
    check("post_reset_result", 40'({res_data, res_tag}), 40'({8'h33, 4'd6}));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the 8-bit power ALU. Accepts tagged ALU commands (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU's registered inputs, waits out the ALU's fixed pipeline latency, then captures aluOut/aluCout/aluOF into a result register offered downstream with valid/ready. Only one command is in flight at a time, so results return in order and are always matched to their tag.

## Interface
- DEPTH, 4, command FIFO depth in entries (power of two, ≥2)
- ALU_LAT, 4, clock edges from the ALU sampling its inputs to aluOut/aluCout/aluOF being valid (≥1)
- TAG_W, 4, width of the command tag carried through to the result
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_opcode  input  4  ALU opcode
- cmd_a, cmd_b  input  8  operands
- cmd_tag  input  TAG_W  user tag
- alu_enable  output  1  to ALU enable
- alu_opcode  output  4  to ALU opcode
- alu_a, alu_b  output  8  to ALU a, b
- alu_out  input  8  from ALU aluOut
- alu_cout, alu_of  input  1  from ALU aluCout, aluOF
- res_valid  output  1  result held
- res_ready  input  1  downstream accepts
- res_data  output  8  captured alu_out
- res_cout, res_of  output  1  captured flags
- res_tag  output  TAG_W  tag of the completed command

## Operation
- Push when cmd_valid && cmd_ready. Pop only in IDLE when the FIFO is non-empty. A push and a pop in the same cycle are both honoured, except that when the FIFO is full no push occurs because cmd_ready=0.
- FSM states and transitions:
  - IDLE: if not empty, pop the head, load alu_opcode/alu_a/alu_b and the in-flight tag, set alu_enable=1, and go to ISSUE.
  - ISSUE: one cycle; load wait counter = 1; go to WAIT.
  - WAIT: increment the counter. When counter == ALU_LAT, capture alu_out/alu_cout/alu_of plus the tag into the res_* registers, set res_valid=1, and go to DONE.
  - DONE: hold until res_valid && res_ready, then clear res_valid and go to IDLE.
- alu_opcode/alu_a/alu_b are held stable from ISSUE until leaving DONE.
- alu_enable is 1 from the edge entering ISSUE until the edge leaving DONE.
- The result is a raw capture with no arithmetic; widths match the ALU (8-bit data, 1-bit flags).
- res_ready low stalls the FSM in DONE. The FIFO keeps accepting commands until full.
- FIFO empty: the FSM stays in IDLE and all alu_* outputs keep their last values with alu_enable=0.
- Reset asserted at any point, including mid-WAIT: FIFO flushed, in-flight command dropped, no result produced.

## Timing
- Reset values:
  - cmd_ready=1 (after reset deassertion the FIFO is empty)
  - alu_enable=0, alu_opcode=0, alu_a=0, alu_b=0
  - res_valid=0, res_data=0, res_cout=0, res_of=0, res_tag=0
  - FSM in IDLE, FIFO pointers and count at 0
- Idle block, command accepted at edge 0:
  - alu_* outputs valid after edge 1.
  - Result captured at edge ALU_LAT+2; res_valid high after that edge (edge 6 with the default ALU_LAT=4).
- Result accepted at edge N: res_valid low after edge N. The next queued command is popped at edge N+1.
- Back-to-back throughput is one command per ALU_LAT+3 cycles when res_ready is held high.
- All outputs are registered. cmd_ready depends only on the FIFO count.

## Configuration
- ALU_SEQ_STATS_EN defined:
  - Adds outputs stat_done (16 bits) and stat_of (16 bits).
  - stat_done increments on each result handshake. stat_of increments on each result handshake with res_of=1.
  - Both saturate at 16'hFFFF and clear on reset.
- ALU_SEQ_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package alu_seq_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, DONE)
  - the opcode width constant (4) and data width constant (8)
  - the command struct {opcode, a, b, tag}
- Sub-module alu_cmd_fifo: synchronous FIFO, DEPTH×command struct, with push/pop/full/empty/count. All FSM logic stays in the top level.

## Test plan
- Reset then a single command {opcode=2, a=8'h05, b=8'h03, tag=1}, with the ALU model returning 8'h08 -> alu_enable rises after edge 1; res_valid after edge 6 with res_data=8'h08, res_tag=1.
- Push 5 commands with res_ready=0 and DEPTH=4 -> cmd_ready drops after the FIFO fills. With one command in flight, 5 are accepted and the 6th is refused; no data loss.
- Four commands with tags 0..3 and res_ready=1 -> results return in tag order 0,1,2,3, spaced ALU_LAT+3 cycles apart.
- ALU model returns aluOut=8'h00 with aluCout=1 and aluOF=1 for 8'hFF+8'h01 -> res_cout=1, res_of=1; stat_of increments when the macro is defined.
- Reset asserted during WAIT with 2 commands queued -> all outputs return to reset values immediately; res_valid never rises for the dropped commands.
- res_ready held low for 10 cycles in DONE -> res_* held stable and alu_* held stable; one handshake occurs when res_ready rises.
